// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, the PC, instruction memory and the execution unit.
// master is the sequencer side; slave is the surrounding datapath/memory side.
interface fetch_sequencer_if;
    logic        start;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        exec_done;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        mem_rd;
    logic        pc_inc;
    logic        pc_ld;
    logic [15:0] pc_d;
    logic [15:0] ir;
    logic        exec_go;
    logic [15:0] instr_count;
    logic        halted;
    logic        fault;

    modport master (
        input  start, mem_ready, mem_rdata, exec_done, branch_taken, branch_target,
        output mem_rd, pc_inc, pc_ld, pc_d, ir, exec_go, instr_count, halted, fault
    );

    modport slave (
        output start, mem_ready, mem_rdata, exec_done, branch_taken, branch_target,
        input  mem_rd, pc_inc, pc_ld, pc_d, ir, exec_go, instr_count, halted, fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch / decode / execute control FSM for the Lab 7 CPU: drives PC inc/ld, the IR,
// the execution-unit launch pulse, and stops on HALT or a fetch timeout.
module fetch_sequencer #(
    parameter logic [3:0] OP_HALT = 4'hF,
    parameter int         TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [15:0] r_ir, r_instr_count;
    logic [7:0]  r_wait;
    logic        r_halted, r_fault;
    logic        w_mem_rd, w_pc_inc, w_pc_ld, w_exec_go;
    logic        w_is_halt, w_timeout;

    assign w_is_halt = (r_ir[15:12] == OP_HALT);
    assign w_timeout = (r_wait == WAIT_LAST);

    always_comb begin
        w_next    = r_state;
        w_mem_rd  = 1'b0;
        w_pc_inc  = 1'b0;
        w_pc_ld   = 1'b0;
        w_exec_go = 1'b0;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_FETCH;
            S_FETCH: begin
                w_mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    w_pc_inc = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                if (w_is_halt) begin
                    w_next = S_HALT;
                end else begin
                    w_exec_go = 1'b1;
                    w_next    = S_EXECUTE;
                end
            end
            // branch_taken only matters in the exec_done cycle
            S_EXECUTE: begin
                if (bus.exec_done) begin
                    w_pc_ld = bus.branch_taken;
                    w_next  = S_FETCH;
                end
            end
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ir          <= 16'h0000;
            r_instr_count <= 16'h0000;
            r_wait        <= 8'h00;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_ir   <= bus.mem_rdata;
                        r_wait <= 8'h00;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'h01;
                    end
                end
                S_DECODE: if (!w_is_halt) r_instr_count <= r_instr_count + 16'h0001;
                default: ;
            endcase
            if (w_next == S_HALT) r_halted <= 1'b1;
        end
    end

    assign bus.mem_rd      = w_mem_rd;
    assign bus.pc_inc      = w_pc_inc;
    assign bus.pc_ld       = w_pc_ld;
    assign bus.exec_go     = w_exec_go;
    assign bus.pc_d        = bus.branch_target;
    assign bus.ir          = r_ir;
    assign bus.instr_count = r_instr_count;
    assign bus.halted      = r_halted;
    assign bus.fault       = r_fault;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: an instruction-level model predicts every output each
// cycle, and hand-computed literals pin the model at the interesting points.
module tb_fetch_sequencer;
    localparam int TIMEOUT = 15;

    // instruction-level phases of the machine as seen from outside
    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3, PH_STOP = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_sequencer_if bus();

    fetch_sequencer #(.OP_HALT(4'hF), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b1;

    // model state
    int          m_phase     = PH_IDLE;
    int          m_fetch_len = 0;
    logic [15:0] m_ir        = 16'h0000;
    logic [15:0] m_count     = 16'h0000;
    logic        m_halted    = 1'b0;
    logic        m_fault     = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase     <= PH_IDLE;
            m_fetch_len <= 0;
            m_ir        <= 16'h0000;
            m_count     <= 16'h0000;
            m_halted    <= 1'b0;
            m_fault     <= 1'b0;
        end else begin
            case (m_phase)
                PH_IDLE: if (bus.start) m_phase <= PH_FETCH;
                PH_FETCH: begin
                    if (bus.mem_ready) begin
                        m_ir        <= bus.mem_rdata;
                        m_fetch_len <= 0;
                        m_phase     <= PH_DECODE;
                    end else if (m_fetch_len + 1 == TIMEOUT) begin
                        m_fault  <= 1'b1;
                        m_halted <= 1'b1;
                        m_phase  <= PH_STOP;
                    end else begin
                        m_fetch_len <= m_fetch_len + 1;
                    end
                end
                PH_DECODE: begin
                    if (m_ir[15:12] == 4'hF) begin
                        m_halted <= 1'b1;
                        m_phase  <= PH_STOP;
                    end else begin
                        m_count <= m_count + 16'h0001;
                        m_phase <= PH_EXEC;
                    end
                end
                PH_EXEC: if (bus.exec_done) m_phase <= PH_FETCH;
                default: ;
            endcase
        end
    end

    int c_rd  = 0;
    int c_inc = 0;
    always @(negedge clk) begin
        if (bus.mem_rd) c_rd  <= c_rd + 1;
        if (bus.pc_inc) c_inc <= c_inc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        logic [53:0] e, a;
        logic e_rd, e_inc, e_ld, e_go;
        e_rd  = (m_phase == PH_FETCH);
        e_inc = (m_phase == PH_FETCH) && bus.mem_ready;
        e_ld  = (m_phase == PH_EXEC) && bus.exec_done && bus.branch_taken;
        e_go  = (m_phase == PH_DECODE) && (m_ir[15:12] != 4'hF);
        e = {e_rd, e_inc, e_ld, e_go, bus.branch_target, m_ir, m_count, m_halted, m_fault};
        a = {bus.mem_rd, bus.pc_inc, bus.pc_ld, bus.exec_go, bus.pc_d, bus.ir,
             bus.instr_count, bus.halted, bus.fault};
        if (reset) begin
            e[53:50] = 4'b0000;
            a[53:50] = 4'b0000;
        end
        chk("cycle{rd,inc,ld,go,pc_d,ir,cnt,halt,fault}", 64'(a), 64'(e));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            if (chk_en) model_cmp();
            @(posedge clk);
        end
        #1;
    endtask

    int s_rd, s_inc;

    initial begin
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.mem_ready     = 1'b0;
        bus.mem_rdata     = 16'h0000;
        bus.exec_done     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 16'h0000;
        cyc(2);
        reset = 1'b0;

        // idle after reset
        cyc(5);
        chk("idle_mem_rd",  64'(bus.mem_rd),      64'd0);
        chk("idle_exec_go", 64'(bus.exec_go),     64'd0);
        chk("idle_ir",      64'(bus.ir),          64'd0);
        chk("idle_count",   64'(bus.instr_count), 64'd0);
        chk("idle_halted",  64'(bus.halted),      64'd0);

        // back-to-back sequential instructions
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        bus.exec_done = 1'b1;
        bus.mem_rdata = 16'h1234;
        cyc(1);
        chk("fetch1_pc_inc", 64'(bus.pc_inc), 64'd1);
        cyc(1);
        chk("ir_1234",       64'(bus.ir),      64'h1234);
        chk("go_after_load", 64'(bus.exec_go), 64'd1);
        bus.mem_rdata = 16'h2000;
        cyc(5);
        chk("count_2",  64'(bus.instr_count), 64'd2);
        chk("ir_2000",  64'(bus.ir),          64'h2000);

        // branch: taken without done is ignored, then done+taken loads
        bus.exec_done     = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 16'h0040;
        cyc(2);
        chk("taken_no_done_ld", 64'(bus.pc_ld), 64'd0);
        cyc(1);
        bus.exec_done = 1'b1;
        #1;
        chk("branch_pc_ld",  64'(bus.pc_ld),  64'd1);
        chk("branch_pc_d",   64'(bus.pc_d),   64'h0040);
        chk("branch_pc_inc", 64'(bus.pc_inc), 64'd0);
        cyc(1);
        chk("refetch_mem_rd", 64'(bus.mem_rd), 64'd1);
        bus.branch_taken = 1'b0;

        // memory stall of 4 cycles
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h3000;
        s_rd = c_rd; s_inc = c_inc;
        cyc(4);
        bus.mem_ready = 1'b1;
        cyc(1);
        chk("stall_rd_cycles", 64'(c_rd - s_rd),   64'd5);
        chk("stall_inc_once",  64'(c_inc - s_inc), 64'd1);
        chk("stall_ir",        64'(bus.ir),        64'h3000);

        // fetch timeout
        bus.mem_ready = 1'b0;
        cyc(2);
        s_inc = c_inc;
        cyc(14);
        chk("pre_timeout_halted", 64'(bus.halted), 64'd0);
        chk("pre_timeout_rd",     64'(bus.mem_rd), 64'd1);
        cyc(1);
        chk("timeout_fault",  64'(bus.fault),      64'd1);
        chk("timeout_halted", 64'(bus.halted),     64'd1);
        chk("timeout_no_inc", 64'(c_inc - s_inc),  64'd0);
        chk("timeout_ir",     64'(bus.ir),         64'h3000);

        // HALT opcode
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("rst_fault", 64'(bus.fault),       64'd0);
        chk("rst_count", 64'(bus.instr_count), 64'd0);
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hF000;
        cyc(2);
        chk("halt_op_no_go", 64'(bus.exec_go), 64'd0);
        chk("halt_op_ir",    64'(bus.ir),      64'hF000);
        cyc(1);
        chk("halt_halted", 64'(bus.halted),      64'd1);
        chk("halt_fault",  64'(bus.fault),       64'd0);
        chk("halt_count",  64'(bus.instr_count), 64'd0);
        bus.start = 1'b0; cyc(1);
        bus.start = 1'b1; cyc(1);
        bus.start = 1'b0; cyc(2);
        chk("halt_sticky", 64'(bus.halted), 64'd1);
        chk("halt_no_rd",  64'(bus.mem_rd), 64'd0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("halt_rst_halted", 64'(bus.halted), 64'd0);
        chk("halt_rst_ir",     64'(bus.ir),     64'd0);

        // instruction counter wrap after 65536 launches
        bus.mem_rdata = 16'h1000;
        bus.start     = 1'b1;
        chk_en        = 1'b0;
        cyc(196600);
        chk_en = 1'b1;
        cyc(7);
        chk("count_ffff", 64'(bus.instr_count), 64'hFFFF);
        cyc(1);
        chk("count_wrap", 64'(bus.instr_count), 64'h0000);

        // reset in a FETCH cycle with mem_ready high
        reset = 1'b1;
        cyc(1);
        reset         = 1'b0;
        bus.mem_rdata = 16'hABCD;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("midfetch_rst_ir",    64'(bus.ir),          64'd0);
        chk("midfetch_rst_count", 64'(bus.instr_count), 64'd0);
        chk("midfetch_rst_rd",    64'(bus.mem_rd),      64'd0);
        cyc(2);
        chk("midfetch_idle_rd",   64'(bus.mem_rd),      64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
